// File: rtl/tdm_mux4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mux4
// Purpose  : 4-to-1 time-division multiplexer. Arbitrates four valid/ready
//            source channels onto one registered output stream and tags each
//            beat with its 2-bit source code {out_S1,out_S0} so a downstream
//            1-to-4 demux can route it back.
// Ports    : clk, rst_n (async active-low)
//            Enable            - 0 blocks new grants; a held beat still drains
//            in_data/in_valid  - channel i data at [i*WIDTH +: WIDTH]
//            in_ready          - one-hot (or zero) grant back to the channels
//            out_data/out_S0/out_S1/out_valid - registered output beat
//            out_ready         - downstream accepts the beat
//            busy              - mirrors out_valid
// Config   : TDM_FIXED_PRIORITY_EN defined -> fixed priority, ch0 highest,
//            no round-robin pointer. Undefined (default) -> round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Enable,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_S0,
  output logic               out_S1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q;
  logic [1:0]         src_q;

  logic               w_load_ok;
  logic [3:0]         w_req;
  logic               w_grant_vld;
  logic [1:0]         w_grant_idx;

`ifndef TDM_FIXED_PRIORITY_EN
  logic [1:0]         rr_ptr_q;
  logic [1:0]         w_idx;
`endif

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 2'd0;
    w_load_ok   = (state_q == EMPTY) | out_ready;
    // Gating with rst_n keeps in_ready low for the whole reset window.
    w_req       = (Enable & w_load_ok & rst_n) ? in_valid : 4'b0000;
`ifdef TDM_FIXED_PRIORITY_EN
    // Scan high-to-low so the lowest-index requester is the last one written.
    for (int i = 3; i >= 0; i--) begin
      if (w_req[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = 2'(i);
      end
    end
`else
    w_idx = 2'd0;
    // Search rr_ptr+1 .. rr_ptr+4; the 2-bit add wraps mod 4, so the last
    // step revisits the previous winner, letting a sole requester repeat.
    for (int k = 1; k <= 4; k++) begin
      w_idx = rr_ptr_q + 2'(k);
      if (!w_grant_vld && w_req[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
`endif
    in_ready = w_grant_vld ? (4'b0001 << w_grant_idx) : 4'b0000;
  end

  // --------------------------------------------------------------------------
  // Output slot state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (w_grant_vld) state_d = FULL;
      FULL:    if (out_ready && !w_grant_vld) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      src_q    <= 2'd0;
`ifndef TDM_FIXED_PRIORITY_EN
      rr_ptr_q <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      // Data and source code only change on a transfer; a plain drain leaves
      // them holding the last beat.
      if (w_grant_vld) begin
        data_q   <= in_data[w_grant_idx*WIDTH +: WIDTH];
        src_q    <= w_grant_idx;
`ifndef TDM_FIXED_PRIORITY_EN
        rr_ptr_q <= w_grant_idx;
`endif
      end
    end
  end

  assign out_data  = data_q;
  assign out_S0    = src_q[0];
  assign out_S1    = src_q[1];
  assign out_valid = (state_q == FULL);
  assign busy      = out_valid;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mux4
// Purpose  : Self-checking bench for tdm_mux4. Stimulus pushes expected
//            {code,data} beats into a queue; a monitor pops and compares
//            each accepted output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mux4;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               Enable;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_S0;
  logic               out_S1;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int nvec = 0;
  int nerr = 0;
  logic [9:0] exp_q[$];

  tdm_mux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Enable    (Enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_S0    (out_S0),
    .out_S1    (out_S1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] code, input logic [7:0] data);
    exp_q.push_back({code, data});
  endtask

  // Monitor: every accepted output beat is compared against the queue head.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      chk("busy_eq_valid", 32'(busy), 32'(out_valid));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_beat: got code %0d data %0h, expected none", {out_S1, out_S0}, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_code", 32'({out_S1, out_S0}), 32'(e[9:8]));
          chk("beat_data", 32'(out_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1. Reset with all channels valid ----
    rst_n     = 1'b0;
    Enable    = 1'b1;
    out_ready = 1'b1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_code", 32'({out_S1, out_S0}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_ch0", 32'(in_ready), 32'b0001);

    // ---- 2. All four valid: round-robin rotation ----
`ifdef TDM_FIXED_PRIORITY_EN
    for (int i = 0; i < 5; i++) push(2'd0, 8'h11);
`else
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    push(2'd0, 8'h11);
`endif
    repeat (5) tick();
    in_valid = 4'b0000;
    tick();
    @(negedge clk);
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drain_holds_data", 32'(out_data), 32'h11);

    // ---- 3. Backpressure ----
    tick();
    in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    push(2'd2, 8'hA5);
    tick();
    in_valid = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hA5);
      chk("bp_code", 32'({out_S1, out_S0}), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
`ifdef TDM_FIXED_PRIORITY_EN
    push(2'd0, 8'h11);
`else
    push(2'd3, 8'h44);
`endif
    tick();
    in_valid = 4'b0000;
    tick();

    // ---- Sole requester regranted every cycle ----
    in_data  = {8'h44, 8'h3C, 8'h22, 8'h11};
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) push(2'd2, 8'h3C);
    repeat (3) tick();
    in_valid = 4'b0000;
    tick();

    // ---- 4. Enable low blocks grants ----
    Enable   = 1'b0;
    in_data  = {8'h44, 8'h33, 8'h5A, 8'h11};
    in_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("dis_valid", 32'(out_valid), 32'd0);
      chk("dis_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    Enable = 1'b1;
    push(2'd1, 8'h5A);
    @(negedge clk);
    chk("en_in_ready", 32'(in_ready), 32'b0010);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // ---- 5. Async reset mid-transfer discards held beat ----
    out_ready = 1'b0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h77};
    in_valid  = 4'b0001;
    tick();
    in_valid = 4'b0000;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
